// File: rtl/alu_result_select_pipe_if.sv
// Bundles the ALU-side operand/command inputs and the consumer-side result
// handshake of the registered result select.
interface alu_result_select_pipe_if #(
  parameter int WIDTH   = 32,
  parameter int NUM_OPS = 6
);
  logic [NUM_OPS-1:0]       command;
  logic [NUM_OPS*WIDTH-1:0] in_data;
  logic [NUM_OPS-1:0]       in_flag;
  logic                     in_valid;
  logic                     in_ready;
  logic [WIDTH-1:0]         out_data;
  logic                     out_flag;
  logic                     out_err;
  logic                     out_valid;
  logic                     out_ready;

  modport master (
    output command, in_data, in_flag, in_valid, out_ready,
    input  in_ready, out_data, out_flag, out_err, out_valid
  );

  modport slave (
    input  command, in_data, in_flag, in_valid, out_ready,
    output in_ready, out_data, out_flag, out_err, out_valid
  );
endinterface

// File: rtl/alu_result_select_pipe.sv
// One-hot ALU result select with illegal-command detection, a 2-entry
// valid/ready output buffer and a saturating illegal-command counter.
module alu_result_select_pipe #(
  parameter int WIDTH     = 32,
  parameter int NUM_OPS   = 6,
  parameter int CNT_WIDTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  alu_result_select_pipe_if.slave  bus,
  input  logic                     err_clr,
  output logic [CNT_WIDTH-1:0]     err_count
);

  localparam int ENTRY_W = WIDTH + 2;
  localparam int PCW     = $clog2(NUM_OPS + 1);

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  function automatic logic [PCW-1:0] popcount(input logic [NUM_OPS-1:0] v);
    logic [PCW-1:0] n;
    n = {PCW{1'b0}};
    for (int i = 0; i < NUM_OPS; i++) begin
      n = n + {{(PCW-1){1'b0}}, v[i]};
    end
    return n;
  endfunction

  occ_e                 state_q, state_d;
  logic [ENTRY_W-1:0]   head_q, head_d;
  logic [ENTRY_W-1:0]   tail_q, tail_d;
  logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

  logic [WIDTH-1:0]     sel_data_s;
  logic                 sel_flag_s;
  logic                 sel_err_s;
  logic [ENTRY_W-1:0]   new_entry_s;
  logic                 in_ready_s;
  logic                 out_valid_s;
  logic                 push_s;
  logic                 pop_s;

  // Input-side select: only an exactly-one-hot command forwards a slice.
  always_comb begin
    sel_data_s = {WIDTH{1'b0}};
    sel_flag_s = 1'b0;
    sel_err_s  = 1'b1;
    if (popcount(bus.command) == {{(PCW-1){1'b0}}, 1'b1}) begin
      sel_err_s = 1'b0;
      for (int i = 0; i < NUM_OPS; i++) begin
        if (bus.command[i]) begin
          sel_data_s = bus.in_data[i*WIDTH +: WIDTH];
          sel_flag_s = bus.in_flag[i];
        end else begin
          sel_data_s = sel_data_s;
          sel_flag_s = sel_flag_s;
        end
      end
    end else begin
      sel_err_s  = 1'b1;
    end
  end

  assign new_entry_s = {sel_err_s, sel_flag_s, sel_data_s};
  assign in_ready_s  = (state_q != OCC_FULL);
  assign out_valid_s = (state_q != OCC_EMPTY);
  assign push_s      = bus.in_valid & in_ready_s;
  assign pop_s       = out_valid_s & bus.out_ready;

  // Buffer occupancy and entry movement; head keeps its value when drained.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      OCC_EMPTY: begin
        if (push_s) begin
          head_d  = new_entry_s;
          state_d = OCC_ONE;
        end else begin
          state_d = OCC_EMPTY;
        end
      end
      OCC_ONE: begin
        if (push_s && pop_s) begin
          head_d = new_entry_s;
        end else if (push_s) begin
          tail_d  = new_entry_s;
          state_d = OCC_FULL;
        end else if (pop_s) begin
          state_d = OCC_EMPTY;
        end else begin
          state_d = OCC_ONE;
        end
      end
      OCC_FULL: begin
        if (pop_s) begin
          head_d  = tail_q;
          state_d = OCC_ONE;
        end else begin
          state_d = OCC_FULL;
        end
      end
      default: begin
        state_d = OCC_EMPTY;
      end
    endcase
  end

  // Illegal-command counter: a clear in the same cycle as an error keeps that error.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_clr) begin
      err_cnt_d = (push_s && sel_err_s) ? {{(CNT_WIDTH-1){1'b0}}, 1'b1} : {CNT_WIDTH{1'b0}};
    end else if (push_s && sel_err_s && (err_cnt_q != {CNT_WIDTH{1'b1}})) begin
      err_cnt_d = err_cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // State, buffer and counter registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= OCC_EMPTY;
      head_q    <= {ENTRY_W{1'b0}};
      tail_q    <= {ENTRY_W{1'b0}};
      err_cnt_q <= {CNT_WIDTH{1'b0}};
    end else begin
      state_q   <= state_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_s;
  assign bus.out_data  = head_q[WIDTH-1:0];
  assign bus.out_flag  = head_q[WIDTH];
  assign bus.out_err   = head_q[WIDTH+1];
  assign err_count     = err_cnt_q;

endmodule

// File: tb/tb_alu_result_select_pipe.sv
// Randomised scoreboard bench for alu_result_select_pipe with the directed
// scenarios run first; expected results come from a plain behavioural model.
module tb_alu_result_select_pipe;

  localparam int W  = 32;
  localparam int N  = 6;
  localparam int CW = 2;

  logic          clock;
  logic          reset;
  logic          err_clr;
  logic [CW-1:0] err_count;

  alu_result_select_pipe_if #(.WIDTH(W), .NUM_OPS(N)) bus ();

  alu_result_select_pipe #(.WIDTH(W), .NUM_OPS(N), .CNT_WIDTH(CW)) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .err_clr   (err_clr),
    .err_count (err_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W+1:0] sb_q[$];
  logic         push_now = 1'b0;
  logic         push_err = 1'b0;
  int           exp_cnt  = 0;
  logic [W+1:0] last_out = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference result: {err, flag, data} from the one-hot rule.
  function automatic logic [W+1:0] model(input logic [N-1:0] cmd,
                                         input logic [N*W-1:0] d,
                                         input logic [N-1:0] f);
    logic [W+1:0] r;
    r = {1'b1, 1'b0, {W{1'b0}}};
    if ($countones(cmd) == 1) begin
      for (int i = 0; i < N; i++) begin
        if (cmd[i]) r = {1'b0, f[i], d[i*W +: W]};
      end
    end
    return r;
  endfunction

  function automatic logic [N*W-1:0] rnd_data();
    logic [N*W-1:0] r;
    for (int i = 0; i < N; i++) r[i*W +: W] = $urandom;
    return r;
  endfunction

  function automatic logic [N*W-1:0] with_op(input logic [N*W-1:0] base, input int op,
                                             input logic [W-1:0] v);
    logic [N*W-1:0] r;
    r = base;
    r[op*W +: W] = v;
    return r;
  endfunction

  task automatic drive(input logic v, input logic [N-1:0] cmd, input logic [N*W-1:0] d,
                       input logic [N-1:0] f, input logic ordy, input logic clr,
                       input logic rst);
    logic [W+1:0] e;
    @(negedge clock);
    bus.in_valid  = v;
    bus.command   = cmd;
    bus.in_data   = d;
    bus.in_flag   = f;
    bus.out_ready = ordy;
    err_clr       = clr;
    reset         = rst;
    #1;
    e        = model(cmd, d, f);
    push_now = v && bus.in_ready && !rst;
    push_err = push_now && e[W+1];
    if (push_now) sb_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, rnd_data(), rnd_data(), $urandom, 1'b1, 1'b0, 1'b0);
  endtask

  // Monitor: checks handshake, head entry, hold-when-empty and the counter each cycle.
  initial begin
    int older;
    forever begin
      @(negedge clock);
      #2;
      if (reset) begin
        sb_q.delete();
        exp_cnt  = 0;
        last_out = '0;
      end else begin
        older = sb_q.size() - (push_now ? 1 : 0);
        chk("out_valid", 64'(bus.out_valid), 64'(older > 0));
        chk("in_ready", 64'(bus.in_ready), 64'(older < 2));
        chk("err_count", 64'(err_count), 64'(exp_cnt));
        if (bus.out_valid && older > 0) begin
          chk("head", 64'({bus.out_err, bus.out_flag, bus.out_data}), 64'(sb_q[0]));
          if (bus.out_ready) last_out = sb_q.pop_front();
        end else if (!bus.out_valid) begin
          chk("empty_hold", 64'({bus.out_err, bus.out_flag, bus.out_data}), 64'(last_out));
        end
        if (err_clr) exp_cnt = push_err ? 1 : 0;
        else if (push_err && exp_cnt < (1 << CW) - 1) exp_cnt = exp_cnt + 1;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N*W-1:0] d;
    logic [N-1:0]   cmd;
    reset = 1'b1; err_clr = 1'b0;
    bus.in_valid = 1'b0; bus.command = '0; bus.in_data = '0; bus.in_flag = '0;
    bus.out_ready = 1'b0;
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1);

    // First legal select
    d = with_op(with_op(rnd_data(), 1, 32'hDEADBEEF), 0, 32'h1);
    drive(1'b1, 6'b000010, d, 6'b000010, 1'b1, 1'b0, 1'b0);
    idle(2);

    // Stall: two entries fill the buffer, third offer is refused
    drive(1'b1, 6'b000001, with_op(rnd_data(), 0, 32'h11), 6'b000000, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 6'b001000, with_op(rnd_data(), 3, 32'h33), 6'b001000, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 6'b000100, rnd_data(), 6'b111111, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 6'b000100, rnd_data(), 6'b111111, 1'b0, 1'b0, 1'b0);
    idle(3);

    // Illegal commands
    drive(1'b1, 6'b000011, rnd_data(), 6'b111111, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 6'b000000, rnd_data(), 6'b111111, 1'b1, 1'b0, 1'b0);
    idle(2);

    // Saturation, clear-with-error, clear alone
    drive(1'b0, '0, rnd_data(), '0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b1, 6'b110000, rnd_data(), $urandom, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 6'b111111, rnd_data(), $urandom, 1'b1, 1'b1, 1'b0);
    drive(1'b0, '0, rnd_data(), '0, 1'b1, 1'b1, 1'b0);
    idle(2);

    // Throughput at occupancy 1
    drive(1'b1, 6'b100000, with_op(rnd_data(), 5, 32'h0), 6'b100000, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 10; k++)
      drive(1'b1, 6'b100000, with_op(rnd_data(), 5, 32'(k)), 6'(k), 1'b1, 1'b0, 1'b0);
    idle(3);

    // Reset mid-operation
    drive(1'b1, 6'b000100, rnd_data(), 6'b000100, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 6'b000011, rnd_data(), 6'b000100, 1'b0, 1'b0, 1'b0);
    drive(1'b0, '0, rnd_data(), '0, 1'b1, 1'b0, 1'b1);
    idle(4);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 9) < 7) cmd = 6'b000001 << $urandom_range(0, N-1);
      else cmd = 6'($urandom);
      drive(1'($urandom_range(0, 3) != 0), cmd, rnd_data(), 6'($urandom),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0),
            1'($urandom_range(0, 299) == 0));
    end
    idle(4);
    chk("drained", 64'(sb_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
